// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: packed input lanes, manual select, mode/enable
// controls and the registered sample outputs with their status pulses.
interface mux_scan_sel_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) ();
    logic [CHANNELS*WIDTH-1:0] I;
    logic [SEL_W-1:0]          Sel;
    logic                      mode;
    logic                      en;
    logic [WIDTH-1:0]          Out;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      scan_wrap;
    logic                      sel_err;

    // Producer of lanes/controls, consumer of samples
    modport master (
        output I, Sel, mode, en,
        input  Out, out_ch, out_valid, scan_wrap, sel_err
    );

    // The multiplexer itself
    modport slave (
        input  I, Sel, mode, en,
        output Out, out_ch, out_valid, scan_wrap, sel_err
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered N-channel x W-bit multiplexer with manual and auto-scan modes.
// Manual mode samples the lane chosen by Sel every cycle; scan mode walks all
// lanes, dwelling DWELL cycles on each, and pulses scan_wrap on the last lane.
module mux_scan_sel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4,
    parameter int DWELL    = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_sel_if.slave bus
);
    // A one-bit dwell counter is kept even for DWELL=1 so the logic stays uniform
    localparam int                DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]   LAST_DW = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_r;
    logic [SEL_W-1:0] ch_cnt_r;
    logic [DW_W-1:0]  dwell_cnt_r;

    logic [WIDTH-1:0] man_data_s;
    logic [WIDTH-1:0] scan_data_s;
    logic             sel_bad_s;

    // Lane extraction; an index with no matching lane yields all zeros, which is
    // exactly the value Out must take for an out-of-range manual select.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [CHANNELS*WIDTH-1:0] lanes,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                res = lanes[k*WIDTH +: WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Lane selection for both modes plus the manual range check
    always_comb begin
        man_data_s  = pick_channel(bus.I, bus.Sel);
        scan_data_s = pick_channel(bus.I, ch_cnt_r);
        sel_bad_s   = (32'(bus.Sel) >= 32'(CHANNELS));
    end

    // Mode FSM with registered sample, channel tag and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            ch_cnt_r      <= '0;
            dwell_cnt_r   <= '0;
            bus.Out       <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            bus.scan_wrap <= 1'b0;
            bus.sel_err   <= 1'b0;
        end else begin
            // Pulses default low; only a sampling edge raises them
            bus.out_valid <= 1'b0;
            bus.scan_wrap <= 1'b0;
            bus.sel_err   <= 1'b0;

            if (!bus.en) begin
                // Disabled: Out/out_ch and the scan counters freeze
                state_r <= IDLE;
            end else if (!bus.mode) begin
                // Manual sampling starts on the very edge the mode is seen
                state_r       <= MANUAL;
                bus.Out       <= man_data_s;
                bus.out_ch    <= bus.Sel;
                bus.out_valid <= 1'b1;
                bus.sel_err   <= sel_bad_s;
            end else if (state_r != SCAN) begin
                // Scan entry always restarts from lane 0 and produces no sample
                state_r     <= SCAN;
                ch_cnt_r    <= '0;
                dwell_cnt_r <= '0;
            end else if (dwell_cnt_r == LAST_DW) begin
                state_r       <= SCAN;
                dwell_cnt_r   <= '0;
                bus.Out       <= scan_data_s;
                bus.out_ch    <= ch_cnt_r;
                bus.out_valid <= 1'b1;
                bus.scan_wrap <= (ch_cnt_r == LAST_CH);
                ch_cnt_r      <= (ch_cnt_r == LAST_CH) ? '0 : ch_cnt_r + SEL_W'(1);
            end else begin
                state_r     <= SCAN;
                dwell_cnt_r <= dwell_cnt_r + DW_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel: a 16-lane DWELL=4 instance and a 12-lane
// DWELL=1 instance. Stimulus pushes expected samples (with the edge number on
// which they must appear); per-instance monitors pop and compare on out_valid.
module tb_mux_scan_sel;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] edge_cnt = 32'd0;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [7:0]  data;
        logic [3:0]  ch;
        logic        wrap;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    mux_scan_sel_if #(.WIDTH(8), .CHANNELS(16), .SEL_W(4)) bus_a ();
    mux_scan_sel_if #(.WIDTH(8), .CHANNELS(12), .SEL_W(4)) bus_b ();

    mux_scan_sel #(.WIDTH(8), .CHANNELS(16), .SEL_W(4), .DWELL(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux_scan_sel #(.WIDTH(8), .CHANNELS(12), .SEL_W(4), .DWELL(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 32'd1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h expected no pulse (edge %0d)", name, got, edge_cnt);
    endtask

    function automatic exp_t mk(input logic [31:0] at, input logic [7:0] d,
                                input logic [3:0] ch, input logic w, input logic e);
        exp_t r;
        r.at = at; r.data = d; r.ch = ch; r.wrap = w; r.err = e;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 16-lane instance
    always @(negedge clk) begin
        exp_t g;
        exp_t e;
        g = mk(edge_cnt, bus_a.Out, bus_a.out_ch, bus_a.scan_wrap, bus_a.sel_err);
        if (bus_a.out_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                flag("a_unexpected_valid", {18'd0, g});
            end else begin
                e = q_a.pop_front();
                check("a_sample", {18'd0, g}, {18'd0, e});
            end
        end else if (bus_a.scan_wrap !== 1'b0 || bus_a.sel_err !== 1'b0) begin
            flag("a_pulse_without_valid", {18'd0, g});
        end
    end

    // Monitor for the 12-lane instance
    always @(negedge clk) begin
        exp_t g;
        exp_t e;
        g = mk(edge_cnt, bus_b.Out, bus_b.out_ch, bus_b.scan_wrap, bus_b.sel_err);
        if (bus_b.out_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                flag("b_unexpected_valid", {18'd0, g});
            end else begin
                e = q_b.pop_front();
                check("b_sample", {18'd0, g}, {18'd0, e});
            end
        end else if (bus_b.scan_wrap !== 1'b0 || bus_b.sel_err !== 1'b0) begin
            flag("b_pulse_without_valid", {18'd0, g});
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [3:0]  b_sel [4];
        logic [7:0]  b_exp [4];
        logic [3:0]  m_sel [3];
        logic [7:0]  m_exp [3];
        logic        m_err [3];

        b_sel = '{4'd3, 4'd12, 4'd15, 4'd0};
        b_exp = '{8'h3C, 8'hC3, 8'hF0, 8'h0F};
        m_sel = '{4'd13, 4'd11, 4'd12};
        m_exp = '{8'h00, 8'h1B, 8'h00};
        m_err = '{1'b1, 1'b0, 1'b1};

        bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.Sel = 4'd0;
        for (int k = 0; k < 16; k++) bus_a.I[k*8 +: 8] = 8'h10 + 8'(k);
        bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.Sel = 4'd0;
        for (int k = 0; k < 12; k++) bus_b.I[k*8 +: 8] = 8'h10 + 8'(k);
        rst = 1'b1;

        // Reset held with scan requested: all outputs must be zero
        repeat (3) begin
            tick();
            check("a_reset", {49'd0, bus_a.Out, bus_a.out_ch, bus_a.out_valid, bus_a.scan_wrap, bus_a.sel_err}, 64'd0);
            check("b_reset", {49'd0, bus_b.Out, bus_b.out_ch, bus_b.out_valid, bus_b.scan_wrap, bus_b.sel_err}, 64'd0);
        end

        // Release: entry edge e0, then one sample every 4 edges, wrapping after ch 15
        rst = 1'b0;
        e0 = edge_cnt + 32'd1;
        for (int k = 0; k < 23; k++)
            q_a.push_back(mk(e0 + 32'(4 * (k + 1)), 8'h10 + 8'(k % 16), 4'(k % 16), (k % 16) == 15, 1'b0));
        while (edge_cnt + 32'd1 < e0 + 32'd94) tick();

        // Pause while the counter sits at ch 7: Out holds ch 6, no pulses
        bus_a.en = 1'b0;
        repeat (5) begin
            tick();
            check("a_idle_hold", {49'd0, bus_a.Out, bus_a.out_ch, bus_a.out_valid, bus_a.scan_wrap, bus_a.sel_err},
                  {49'd0, 8'h16, 4'd6, 3'b000});
        end

        // Resume scan: restarts from ch 0, four edges after the entry edge
        bus_a.en = 1'b1;
        e1 = edge_cnt + 32'd1;
        for (int k = 0; k < 3; k++)
            q_a.push_back(mk(e1 + 32'(4 * (k + 1)), 8'h10 + 8'(k), 4'(k), 1'b0, 1'b0));
        while (edge_cnt + 32'd1 < e1 + 32'd14) tick();

        // Drop into manual mid-dwell: sampling starts on the switching edge
        bus_a.mode = 1'b0;
        for (int s = 0; s < 16; s++) begin
            bus_a.Sel = 4'(s);
            q_a.push_back(mk(edge_cnt + 32'd1, 8'h10 + 8'(s), 4'(s), 1'b0, 1'b0));
            tick();
        end

        // Second data pattern: lane k = {k, 15-k}
        for (int k = 0; k < 16; k++) bus_a.I[k*8 +: 8] = {4'(k), 4'(15 - k)};
        for (int i = 0; i < 4; i++) begin
            bus_a.Sel = b_sel[i];
            q_a.push_back(mk(edge_cnt + 32'd1, b_exp[i], b_sel[i], 1'b0, 1'b0));
            tick();
        end

        bus_a.en = 1'b0;
        repeat (2) begin
            tick();
            check("a_idle_after_manual", {49'd0, bus_a.Out, bus_a.out_ch, bus_a.out_valid, bus_a.scan_wrap, bus_a.sel_err},
                  {49'd0, 8'h0F, 4'd0, 3'b000});
        end

        // 12-lane instance: out-of-range manual selects raise sel_err with Out=0
        bus_b.en = 1'b1;
        bus_b.mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_b.Sel = m_sel[i];
            q_b.push_back(mk(edge_cnt + 32'd1, m_exp[i], m_sel[i], 1'b0, m_err[i]));
            tick();
        end

        // DWELL=1 scan with an illegal Sel present: one sample per edge, wrap after ch 11
        bus_b.mode = 1'b1;
        bus_b.Sel = 4'd14;
        e2 = edge_cnt + 32'd1;
        for (int k = 0; k < 26; k++)
            q_b.push_back(mk(e2 + 32'd1 + 32'(k), 8'h10 + 8'(k % 12), 4'(k % 12), (k % 12) == 11, 1'b0));
        while (edge_cnt + 32'd1 < e2 + 32'd27) tick();
        bus_b.en = 1'b0;
        repeat (4) tick();

        check("a_queue_empty", 64'(q_a.size()), 64'd0);
        check("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
